// File: rtl/prog_ctr.sv
// Program counter sequencer with a branch-target table lookup.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for Start; PC and BrCount hold their reset values
// RUN    | executing: per edge Halt > Stall > taken branch > increment
// DONE   | halted; PC and BrCount frozen until Start restarts the run
module prog_ctr #(
    parameter int D = 10
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic         Branch,
    input  logic         Taken,
    input  logic         Rel,
    input  logic [3:0]   BrIdx,
    input  logic         Halt,
    input  logic [D-1:0] Target,
    output logic [3:0]   LutAddr,
    output logic [D-1:0] PC,
    output logic         Running,
    output logic         Done,
    output logic [7:0]   BrCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [7:0]   brcnt_q, brcnt_d;

    // State, PC and taken-branch counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            brcnt_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            brcnt_q <= brcnt_d;
        end
    end

    // Next-state and next-PC selection; everything holds unless an action applies
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        brcnt_d = brcnt_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    brcnt_d = '0;
                end
            end
            S_RUN: begin
                if (Halt) begin
                    state_d = S_DONE;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (Branch && Taken) begin
                    // Relative targets are two's complement; the sum wraps modulo 2^D
                    pc_d = Rel ? (pc_q + Target) : Target;
                    if (brcnt_q != 8'hFF) begin
                        brcnt_d = brcnt_q + 8'd1;
                    end
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            S_DONE: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    brcnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
                brcnt_d = '0;
            end
        endcase
    end

    // Table index passes straight through so Target returns in the same cycle
    always_comb begin
        LutAddr = BrIdx;
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        PC      = pc_q;
        BrCount = brcnt_q;
        Running = (state_q == S_RUN);
        Done    = (state_q == S_DONE);
    end

endmodule

// File: doc/prog_ctr.md
PROG_CTR -- requirements
Module: prog_ctr

Interface
REQ-001 SHALL have parameter D, default 10: PC and branch-target width in bits.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Start  input  1  begin or restart program execution.
REQ-005 SHALL have port Stall  input  1  hold PC for this cycle.
REQ-006 SHALL have port Branch  input  1  current instruction is a branch.
REQ-007 SHALL have port Taken  input  1  branch condition true.
REQ-008 SHALL have port Rel  input  1  1 = Target is a signed PC offset; 0 = Target is an absolute address.
REQ-009 SHALL have port BrIdx  input  4  branch-target table index from the instruction.
REQ-010 SHALL have port Halt  input  1  current instruction is the halt instruction.
REQ-011 SHALL have port Target  input  D  table entry returned for LutAddr, same cycle.
REQ-012 SHALL have port LutAddr  output  4  index to the branch-target table.
REQ-013 SHALL have port PC  output  D  current instruction address.
REQ-014 SHALL have port Running  output  1  high while in RUN.
REQ-015 SHALL have port Done  output  1  high while in DONE.
REQ-016 SHALL have port BrCount  output  8  count of taken branches since the last start.

Function
REQ-017 SHALL implement three states: IDLE, RUN and DONE.
REQ-018 SHALL drive LutAddr = BrIdx combinationally in every state, with zero latency.
REQ-019 SHALL, in IDLE with Start=1, move to RUN at the next edge and set PC=0 and BrCount=0; with Start=0 it SHALL remain in IDLE.
REQ-020 SHALL, in RUN, apply exactly one action per edge, in priority order: Halt > Stall > taken branch > increment.
REQ-021 SHALL, on Halt=1 in RUN, move to DONE with PC held.
REQ-022 SHALL, on Stall=1 (Halt=0) in RUN, hold PC and BrCount.
REQ-023 SHALL, on Branch=1 and Taken=1 with Rel=0, load PC with Target.
REQ-024 SHALL, on Branch=1 and Taken=1 with Rel=1, load PC with PC + Target, Target two's complement, result modulo 2^D.
REQ-025 SHALL, on a taken branch, increment BrCount and saturate it at 255.
REQ-026 SHALL, when no higher-priority action applies (including Branch=1, Taken=0), load PC with PC+1 modulo 2^D; PC = 2^D-1 wraps to 0.
REQ-027 SHALL ignore Taken and Rel when Branch=0.
REQ-028 SHALL ignore Start while in RUN.
REQ-029 SHALL, in DONE, hold PC and BrCount and ignore Stall, Branch and Halt.
REQ-030 SHALL, in DONE with Start=1, move to RUN at the next edge with PC=0 and BrCount=0.
REQ-031 SHALL, when Start and Halt are both 1 in IDLE, take Start (Halt is ignored outside RUN).
REQ-032 SHALL derive Running and Done from state only, as Moore outputs with no combinational path from inputs.

Reset
REQ-033 SHALL, on Reset=1 at any time and independent of Clk, force state IDLE, PC=0, BrCount=0, Running=0 and Done=0.
REQ-034 SHALL, on Reset asserted mid-RUN, abandon the in-flight update; the first edge after Reset deasserts evaluates from IDLE.

Verification
REQ-035 SHALL cover basic run: Reset, then Start pulse, then 5 idle cycles -> Running=1, PC steps 0,1,2,3,4,5, BrCount=0.
REQ-036 SHALL cover absolute taken branch: at PC=3, Branch=1, Taken=1, Rel=0, BrIdx=2, Target=80 -> LutAddr=2 the same cycle, PC=80 next cycle, BrCount=1; the same cycle with Taken=0 -> PC=4, BrCount=0.
REQ-037 SHALL cover relative branch and wrap: at PC=5 with Rel=1 and Target=10'h3FB (-5) -> PC=0; PC=1023 with no branch -> PC=0.
REQ-038 SHALL cover priority: Halt, Stall and a taken branch asserted together at PC=7 -> DONE, PC=7, Done=1, BrCount unchanged; Stall plus a taken branch -> PC held, BrCount unchanged.
REQ-039 SHALL cover restart and saturation: 300 taken branches -> BrCount=255; Halt, then Start -> PC=0, BrCount=0, Running=1.
REQ-040 SHALL cover asynchronous reset: Reset asserted between clock edges mid-RUN at PC=42 -> PC=0 and Running=0 immediately, before the next Clk edge.
